// File: rtl/cpu_run_controller.sv
// Run/step/halt sequencer gating the core via cpu_en and cpu_rst_n.
// Define CPU_RUN_BREAKPOINT_EN to compile in the PC breakpoint, BRK state and bp_skip.
module cpu_run_controller #(
    parameter int unsigned RST_HOLD = 4,
    parameter int unsigned PC_W     = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             halt_req,
    input  logic [PC_W-1:0]  pc,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic             bp_valid,
    output logic             cpu_en,
    output logic             cpu_rst_n,
    output logic [2:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        StHold = 3'd0,
        StHalt = 3'd1,
        StRun  = 3'd2,
        StStep = 3'd3,
        StBrk  = 3'd4
    } state_e;

    localparam logic [3:0] HoldLast = 4'(RST_HOLD);

    state_e           state_q;
    logic [3:0]       hold_cnt_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       run_sync_q, step_sync_q, halt_sync_q;
    logic             run_pulse_q, step_pulse_q, halt_pulse_q;
    logic             bp_hit;

    // [0],[1] synchronise, [2] holds the previous level; the pulse itself is registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_sync_q   <= '0;
            step_sync_q  <= '0;
            halt_sync_q  <= '0;
            run_pulse_q  <= 1'b0;
            step_pulse_q <= 1'b0;
            halt_pulse_q <= 1'b0;
        end else begin
            run_sync_q   <= {run_sync_q[1:0], run_req};
            step_sync_q  <= {step_sync_q[1:0], step_req};
            halt_sync_q  <= {halt_sync_q[1:0], halt_req};
            run_pulse_q  <= run_sync_q[1] & ~run_sync_q[2];
            step_pulse_q <= step_sync_q[1] & ~step_sync_q[2];
            halt_pulse_q <= halt_sync_q[1] & ~halt_sync_q[2];
        end
    end

`ifdef CPU_RUN_BREAKPOINT_EN
    logic bp_skip_q;

    assign bp_hit = bp_valid && (pc == bp_addr) && !bp_skip_q;

    // Lets the resumed core execute the breakpoint instruction once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bp_skip_q <= 1'b0;
        end else if (state_q == StHold) begin
            bp_skip_q <= 1'b0;
        end else if (state_q == StBrk && !halt_pulse_q && (step_pulse_q || run_pulse_q)) begin
            bp_skip_q <= 1'b1;
        end else if (cpu_en) begin
            bp_skip_q <= 1'b0;
        end
    end
`else
    logic unused_bp;

    assign bp_hit    = 1'b0;
    assign unused_bp = ^{bp_valid, bp_addr, pc};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StHold;
            hold_cnt_q <= '0;
            cnt_q      <= '0;
        end else begin
            if (state_q == StHold) begin
                cnt_q <= '0;
            end else if (cpu_en && cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            case (state_q)
                StHold: begin
                    if (hold_cnt_q == HoldLast) begin
                        state_q    <= StHalt;
                        hold_cnt_q <= '0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 4'd1;
                    end
                end
                StHalt, StBrk: begin
                    if (!halt_pulse_q) begin
                        if (step_pulse_q) begin
                            state_q <= StStep;
                        end else if (run_pulse_q) begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (halt_pulse_q) begin
                        state_q <= StHalt;
                    end else if (bp_hit) begin
                        state_q <= StBrk;
                    end
                end
                StStep: state_q <= StHalt;
                default: begin
                    state_q    <= StHold;
                    hold_cnt_q <= '0;
                end
            endcase
        end
    end

    assign cpu_en    = (state_q == StStep) || (state_q == StRun && !bp_hit);
    assign cpu_rst_n = state_q inside {StHalt, StRun, StStep, StBrk};
    assign halted    = (state_q == StHalt) || (state_q == StBrk);
    assign state     = state_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Randomised bench for cpu_run_controller against a behavioural reference model.
// Also honours CPU_RUN_BREAKPOINT_EN so either build can be checked.
module tb_cpu_run_controller;

    localparam int unsigned RstHold = 4;
    localparam int unsigned PcW     = 8;
    localparam int unsigned CntW    = 4;
    localparam int          CntMax  = (1 << CntW) - 1;

    localparam int MHold = 0, MHalt = 1, MRun = 2, MStep = 3, MBrk = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            run_req = 1'b0, step_req = 1'b0, halt_req = 1'b0;
    logic [PcW-1:0]  pc = '0;
    logic [PcW-1:0]  bp_addr = 8'h05;
    logic            bp_valid = 1'b0;
    logic            cpu_en, cpu_rst_n, halted;
    logic [2:0]      state;
    logic [CntW-1:0] instr_cnt;

    cpu_run_controller #(
        .RST_HOLD (RstHold),
        .PC_W     (PcW),
        .CNT_W    (CntW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run_req   (run_req),
        .step_req  (step_req),
        .halt_req  (halt_req),
        .pc        (pc),
        .bp_addr   (bp_addr),
        .bp_valid  (bp_valid),
        .cpu_en    (cpu_en),
        .cpu_rst_n (cpu_rst_n),
        .state     (state),
        .halted    (halted),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Stimulus levels, applied to the DUT at the next falling edge.
    bit b_run, b_step, b_halt, b_bpv;
    logic [PcW-1:0] b_bpa = 8'h05;

    // Reference model state.
    int m_state, m_edges, m_cnt;
    bit m_skip, m_en, m_hit, core_adv;
    bit q_run[$], q_step[$], q_halt[$];

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        n_vec++;
        if (got !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state  = MHold;
        m_edges  = 0;
        m_cnt    = 0;
        m_skip   = 1'b0;
        core_adv = 1'b0;
        q_run    = '{0, 0, 0, 0};
        q_step   = '{0, 0, 0, 0};
        q_halt   = '{0, 0, 0, 0};
    endtask

    // A press sampled at edge E-3 that was low at edge E-4 acts at edge E.
    task automatic model_edge();
        bit pr, ps, ph;
        q_run.push_back(b_run);
        q_step.push_back(b_step);
        q_halt.push_back(b_halt);
        pr = q_run[1] && !q_run[0];
        ps = q_step[1] && !q_step[0];
        ph = q_halt[1] && !q_halt[0];
        void'(q_run.pop_front());
        void'(q_step.pop_front());
        void'(q_halt.pop_front());

        m_edges++;
        if (m_en) begin
            if (m_cnt < CntMax) m_cnt++;
            m_skip = 1'b0;
        end
        case (m_state)
            MHold: begin
                m_cnt  = 0;
                m_skip = 1'b0;
                if (m_edges == RstHold + 1) m_state = MHalt;
            end
            MHalt, MBrk: begin
                if (!ph && (ps || pr)) begin
                    if (m_state == MBrk) m_skip = 1'b1;
                    m_state = ps ? MStep : MRun;
                end
            end
            MRun: begin
                if (ph) m_state = MHalt;
                else if (m_hit) m_state = MBrk;
            end
            default: m_state = MHalt;
        endcase
    endtask

    task automatic cycle();
        @(negedge clk);
        if (m_state == MHold) pc = '0;
        else if (core_adv) pc = pc + 1'b1;
        run_req  = b_run;
        step_req = b_step;
        halt_req = b_halt;
        bp_valid = b_bpv;
        bp_addr  = b_bpa;
        #1;
        m_hit = 1'b0;
`ifdef CPU_RUN_BREAKPOINT_EN
        m_hit = bp_valid && (pc == bp_addr) && !m_skip;
`endif
        m_en = (m_state == MStep) || (m_state == MRun && !m_hit);
        check("state", 32'(state), m_state);
        check("cpu_en", 32'(cpu_en), int'(m_en));
        check("cpu_rst_n", 32'(cpu_rst_n), int'(m_state != MHold));
        check("halted", 32'(halted), int'(m_state == MHalt || m_state == MBrk));
        check("instr_cnt", 32'(instr_cnt), m_cnt);
        @(posedge clk);
        model_edge();
        core_adv = m_en;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // which: 0 run, 1 step, 2 halt, 3 run+halt together
    task automatic press(input int which, input int gap);
        b_run  = (which == 0 || which == 3);
        b_step = (which == 1);
        b_halt = (which == 2 || which == 3);
        idle(2);
        b_run  = 1'b0;
        b_step = 1'b0;
        b_halt = 1'b0;
        idle(gap);
    endtask

    // Reset asserted mid-cycle; outputs must clear before the next rising edge.
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_cpu_en", 32'(cpu_en), 0);
        check("rst_cpu_rst_n", 32'(cpu_rst_n), 0);
        check("rst_instr_cnt", 32'(instr_cnt), 0);
        check("rst_state", 32'(state), MHold);
        model_reset();
        b_run  = 1'b0;
        b_step = 1'b0;
        b_halt = 1'b0;
        run_req  = 1'b0;
        step_req = 1'b0;
        halt_req = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        async_reset();
        idle(6);
        check("boot_state", 32'(state), MHalt);
        check("boot_halted", 32'(halted), 1);

        for (int i = 0; i < 3; i++) press(1, 5);
        check("step3_cnt", 32'(instr_cnt), 3);
        check("step3_state", 32'(state), MHalt);

        async_reset();
        idle(6);
        b_run = 1'b1;
        idle(2);
        b_run = 1'b0;
        idle(8);
        press(2, 6);
        check("run10_cnt", 32'(instr_cnt), 10);
        check("run10_state", 32'(state), MHalt);

        press(3, 8);
        check("run_halt_state", 32'(state), MHalt);

        async_reset();
        b_bpv = 1'b1;
        b_bpa = 8'h05;
        idle(6);
        press(0, 14);
`ifdef CPU_RUN_BREAKPOINT_EN
        check("bp_state", 32'(state), MBrk);
        check("bp_en", 32'(cpu_en), 0);
        press(0, 6);
        check("bp_resume_state", 32'(state), MRun);
`else
        check("nobp_state", 32'(state), MRun);
`endif
        press(2, 6);
        b_bpv = 1'b0;

        async_reset();
        idle(6);
        press(0, 25);
        press(2, 6);
        check("sat_cnt", 32'(instr_cnt), CntMax);

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 5) == 0) b_run = ~b_run;
            if ($urandom_range(0, 5) == 0) b_step = ~b_step;
            if ($urandom_range(0, 7) == 0) b_halt = ~b_halt;
            if ($urandom_range(0, 19) == 0) b_bpv = ~b_bpv;
            if ($urandom_range(0, 29) == 0) b_bpa = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 149) == 0) async_reset();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
